// File: rtl/morse_keyer.sv
// morse_keyer: turns one Morse character (dot/dash pattern plus element count)
// into a timed key signal. Every mark and gap is metered in dot units. A unit
// is UNIT_TICKS pulses of the divider's tick enable. Inter-element,
// inter-character and word gaps are generated here, so the character source
// issues a single start per character.
module morse_keyer #(
  parameter int UNIT_TICKS = 1  // tick pulses per dot unit, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       space,
  input  logic [4:0] pattern,
  input  logic [2:0] length,
  output logic       key,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    EGAP,
    CGAP,
    WGAP
  } state_t;

  localparam logic [7:0] TCNT_LAST = 8'(UNIT_TICKS - 1);

  state_t     state_reg;
  logic [7:0] tcnt_reg;
  logic [2:0] ucnt_reg;
  logic [2:0] eidx_reg;
  logic [2:0] len_reg;
  logic [4:0] pattern_reg;
  logic       key_reg;
  logic       busy_reg;
  logic       done_reg;

  logic [7:0] tcnt_next;
  logic [2:0] ucnt_next;
  logic [2:0] len_clamped;
  logic [2:0] phase_units;
  logic [7:0] pat_ext;
  logic       unit_end;
  logic       phase_last;
  logic       more_elems;

  // Pad the latched pattern to 8 bits so any 3-bit element index is in range.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pat
      if (gi < 5) begin : g_elem
        assign pat_ext[gi] = pattern_reg[gi];
      end else begin : g_pad
        assign pat_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Lengths beyond five elements are treated as five.
  assign len_clamped = (length > 3'd5) ? 3'd5 : length;

  // A unit completes on the tick that finds the tick counter at its last value.
  assign unit_end   = tick && (tcnt_reg == TCNT_LAST);

  // The final unit of the current phase ends on this edge.
  assign phase_last = unit_end && (ucnt_reg == (phase_units - 3'd1));

  // After the current mark, is there another element to send?
  assign more_elems = (eidx_reg + 3'd1) < len_reg;

  // Number of dot units the current phase lasts.
  always_comb begin
    phase_units = 3'd1;
    case (state_reg)
      MARK:    phase_units = pat_ext[eidx_reg] ? 3'd3 : 3'd1;
      EGAP:    phase_units = 3'd1;
      CGAP:    phase_units = 3'd3;
      WGAP:    phase_units = 3'd4;
      default: phase_units = 3'd1;
    endcase
  end

  // Counter advance within a phase: ticks wrap at the unit boundary, units accumulate.
  always_comb begin
    tcnt_next = tcnt_reg;
    ucnt_next = ucnt_reg;
    if (tick) begin
      if (unit_end) begin
        tcnt_next = 8'd0;
        ucnt_next = ucnt_reg + 3'd1;
      end else begin
        tcnt_next = tcnt_reg + 8'd1;
      end
    end
  end

  // Keyer FSM with registered key/busy/done; counters clear on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      tcnt_reg    <= 8'd0;
      ucnt_reg    <= 3'd0;
      eidx_reg    <= 3'd0;
      len_reg     <= 3'd0;
      pattern_reg <= 5'd0;
      key_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // start outranks space; a tick on the accepting edge is not counted
          if (start) begin
            pattern_reg <= pattern;
            len_reg     <= len_clamped;
            eidx_reg    <= 3'd0;
            tcnt_reg    <= 8'd0;
            ucnt_reg    <= 3'd0;
            busy_reg    <= 1'b1;
            if (len_clamped != 3'd0) begin
              state_reg <= MARK;
              key_reg   <= 1'b1;
            end else begin
              state_reg <= CGAP;
            end
          end else if (space) begin
            tcnt_reg  <= 8'd0;
            ucnt_reg  <= 3'd0;
            busy_reg  <= 1'b1;
            state_reg <= WGAP;
          end
        end

        MARK: begin
          if (phase_last) begin
            tcnt_reg  <= 8'd0;
            ucnt_reg  <= 3'd0;
            key_reg   <= 1'b0;
            state_reg <= more_elems ? EGAP : CGAP;
          end else begin
            tcnt_reg <= tcnt_next;
            ucnt_reg <= ucnt_next;
          end
        end

        EGAP: begin
          if (phase_last) begin
            tcnt_reg  <= 8'd0;
            ucnt_reg  <= 3'd0;
            eidx_reg  <= eidx_reg + 3'd1;
            key_reg   <= 1'b1;
            state_reg <= MARK;
          end else begin
            tcnt_reg <= tcnt_next;
            ucnt_reg <= ucnt_next;
          end
        end

        CGAP, WGAP: begin
          // end of character or word space: release busy and pulse done
          if (phase_last) begin
            tcnt_reg  <= 8'd0;
            ucnt_reg  <= 3'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            tcnt_reg <= tcnt_next;
            ucnt_reg <= ucnt_next;
          end
        end

        default: begin
          state_reg <= IDLE;
          key_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign key  = key_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: two instances (1 and 2 ticks per unit) share stimulus.
// A timeline model expands each accepted request into a per-tick key sequence
// and is compared with both instances every cycle; literal expectations pin it.
module tb_morse_keyer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       start;
  logic       space;
  logic [4:0] pattern;
  logic [2:0] length;
  logic [1:0] key_w;
  logic [1:0] busy_w;
  logic [1:0] done_w;

  int checks = 0;
  int errors = 0;

  // model state per instance (index d has d+1 ticks per unit)
  bit m_tl [2][128];
  int m_len [2];
  int m_pos [2];
  bit m_key [2];
  bit m_busy [2];
  bit m_done [2];

  // observation counters
  int   kc [2];
  int   bc [2];
  int   dc [2];
  int   rc [2];
  logic pk [2];

  logic [7:0] a_key;

  morse_keyer #(.UNIT_TICKS(1)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .space(space),
    .pattern(pattern), .length(length),
    .key(key_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  morse_keyer #(.UNIT_TICKS(2)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .space(space),
    .pattern(pattern), .length(length),
    .key(key_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int u;
      int n;
      int p;
      u = d + 1;
      if (rst) begin
        m_key[d] = 0; m_busy[d] = 0; m_done[d] = 0; m_len[d] = 0; m_pos[d] = 0;
      end else begin
        m_done[d] = 0;
        if (m_busy[d]) begin
          if (tick) begin
            m_pos[d]++;
            if (m_pos[d] >= m_len[d]) begin
              m_busy[d] = 0; m_done[d] = 1; m_key[d] = 0;
            end else begin
              m_key[d] = m_tl[d][m_pos[d]];
            end
          end
        end else if (start) begin
          n = (length > 3'd5) ? 5 : int'(length);
          p = 0;
          for (int i = 0; i < n; i++) begin
            for (int j = 0; j < (pattern[i] ? 3 : 1) * u; j++) begin m_tl[d][p] = 1; p++; end
            if (i < n - 1)
              for (int j = 0; j < u; j++) begin m_tl[d][p] = 0; p++; end
          end
          for (int j = 0; j < 3 * u; j++) begin m_tl[d][p] = 0; p++; end
          m_len[d] = p; m_pos[d] = 0; m_busy[d] = 1; m_key[d] = m_tl[d][0];
        end else if (space) begin
          for (int j = 0; j < 4 * u; j++) m_tl[d][j] = 0;
          m_len[d] = 4 * u; m_pos[d] = 0; m_busy[d] = 1; m_key[d] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      chk1($sformatf("key%0d", d),  key_w[d],  m_key[d]);
      chk1($sformatf("busy%0d", d), busy_w[d], m_busy[d]);
      chk1($sformatf("done%0d", d), done_w[d], m_done[d]);
    end
  endtask

  // One clock: model follows the edge, DUT outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      kc[d] = 0; bc[d] = 0; dc[d] = 0; rc[d] = 0; pk[d] = key_w[d];
    end
  endtask

  task automatic accum();
    for (int d = 0; d < 2; d++) begin
      if (key_w[d] && !pk[d]) rc[d]++;
      kc[d] += int'(key_w[d]);
      bc[d] += int'(busy_w[d]);
      dc[d] += int'(done_w[d]);
      pk[d] = key_w[d];
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      accum();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_w != 2'b00 && n < 200) begin
      step();
      n++;
    end
    chk("wait_idle", int'(busy_w), 0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; space = 1'b0;
    pattern = 5'd0; length = 3'd0;
    a_key = 8'b00011101;

    // reset state
    step(); step(); step();
    chk("reset_key0", int'(key_w[0]), 0);
    chk("reset_busy1", int'(busy_w[1]), 0);
    chk("reset_done0", int'(done_w[0]), 0);
    rst = 1'b0;
    step();

    // "A": dot, gap, dash, char gap with one tick per cycle
    tick = 1'b1; pattern = 5'b00010; length = 3'd2; start = 1'b1;
    clr();
    step();
    start = 1'b0;
    accum();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) chk("a_key_seq", int'(key_w[0]), int'(a_key[i]));
      chk("a_done_pos", int'(done_w[0]), (i == 8) ? 1 : 0);
      if (i < 8) begin step(); accum(); end
    end
    run(12);
    $display("A: key0=%0d busy0=%0d done0=%0d key1=%0d busy1=%0d", kc[0], bc[0], dc[0], kc[1], bc[1]);
    chk("a_key_cycles0", kc[0], 4);
    chk("a_busy_cycles0", bc[0], 8);
    chk("a_marks0", rc[0], 2);
    chk("a_done0", dc[0], 1);
    chk("a_key_cycles1", kc[1], 8);
    chk("a_busy_cycles1", bc[1], 16);
    chk("a_done1", dc[1], 1);
    wait_idle();

    // "E" with a divide-by-10 tick, start aligned with a tick
    pattern = 5'b00000; length = 3'd1; start = 1'b1; tick = 1'b1;
    clr();
    step();
    start = 1'b0;
    accum();
    for (int c = 1; c < 95; c++) begin
      tick = (c % 10 == 0);
      step();
      accum();
    end
    tick = 1'b1;
    $display("E/10: key0=%0d busy0=%0d key1=%0d busy1=%0d", kc[0], bc[0], kc[1], bc[1]);
    chk("e_key_clks0", kc[0], 10);
    chk("e_busy_clks0", bc[0], 40);
    chk("e_done0", dc[0], 1);
    chk("e_key_clks1", kc[1], 20);
    chk("e_busy_clks1", bc[1], 80);
    chk("e_done1", dc[1], 1);
    wait_idle();

    // word space alone
    space = 1'b1;
    clr();
    step();
    space = 1'b0;
    accum();
    run(20);
    $display("SPACE: busy0=%0d busy1=%0d key=%0d/%0d", bc[0], bc[1], kc[0], kc[1]);
    chk("sp_key0", kc[0], 0);
    chk("sp_busy0", bc[0], 4);
    chk("sp_key1", kc[1], 0);
    chk("sp_busy1", bc[1], 8);
    chk("sp_done1", dc[1], 1);
    wait_idle();

    // start and space together: character sent, space dropped
    start = 1'b1; space = 1'b1; pattern = 5'b00000; length = 3'd1;
    clr();
    step();
    start = 1'b0; space = 1'b0;
    accum();
    run(25);
    $display("START+SPACE: key0=%0d busy0=%0d busy1=%0d", kc[0], bc[0], bc[1]);
    chk("ss_key0", kc[0], 1);
    chk("ss_busy0", bc[0], 4);
    chk("ss_busy1", bc[1], 8);
    chk("ss_done0", dc[0], 1);
    wait_idle();

    // "0": five dashes with length clamped from 7, extra starts while busy
    pattern = 5'b11111; length = 3'd7; start = 1'b1;
    clr();
    step();
    start = 1'b0;
    accum();
    for (int s = 1; s < 60; s++) begin
      start = (s == 3 || s == 10 || s == 17);
      if (start) begin pattern = 5'b00000; length = 3'd1; end
      step();
      accum();
    end
    start = 1'b0;
    $display("ZERO: key0=%0d busy0=%0d marks0=%0d busy1=%0d marks1=%0d", kc[0], bc[0], rc[0], bc[1], rc[1]);
    chk("z_busy0", bc[0], 22);
    chk("z_key0", kc[0], 15);
    chk("z_marks0", rc[0], 5);
    chk("z_busy1", bc[1], 44);
    chk("z_marks1", rc[1], 5);
    chk("z_done1", dc[1], 1);
    wait_idle();

    // back to back: start sampled in the done cycle
    pattern = 5'b00000; length = 3'd1; start = 1'b1;
    step();
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!done_w[0] && n < 20) begin step(); n++; end
      chk("b2b_done_seen", int'(done_w[0]), 1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    $display("B2B: key0=%b busy0=%b", key_w[0], busy_w[0]);
    chk("b2b_key0", int'(key_w[0]), 1);
    chk("b2b_busy0", int'(busy_w[0]), 1);
    wait_idle();

    // reset in the middle of a dash
    pattern = 5'b00001; length = 3'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rst_pre_key0", int'(key_w[0]), 1);
    chk("rst_pre_key1", int'(key_w[1]), 1);
    #2 rst = 1'b1;
    #1;
    $display("RST: key=%b busy=%b done=%b", key_w, busy_w, done_w);
    chk("rst_async_key", int'(key_w), 0);
    chk("rst_async_busy", int'(busy_w), 0);
    chk("rst_async_done", int'(done_w), 0);
    step();
    rst = 1'b0;
    clr();
    run(15);
    chk("rst_no_done0", dc[0], 0);
    chk("rst_no_done1", dc[1], 0);
    chk("rst_no_key0", kc[0], 0);

    // normal operation after reset
    pattern = 5'b00010; length = 3'd2; start = 1'b1;
    clr();
    step();
    start = 1'b0;
    accum();
    run(20);
    $display("POST-RST A: key0=%0d busy0=%0d busy1=%0d", kc[0], bc[0], bc[1]);
    chk("post_key0", kc[0], 4);
    chk("post_busy0", bc[0], 8);
    chk("post_done0", dc[0], 1);
    chk("post_busy1", bc[1], 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Converts one Morse character (dot/dash pattern plus element count) into a timed on/off key signal, metering every mark and space in dot units. Sits directly downstream of the clock-divider stage: the divider's one-phase-wide output pulse drives TICK, which is the keyer's time base. The keyer's KEY output drives the tone/LED stage. Inter-element, inter-character and word gaps are generated internally, so the upstream character source only issues one START per character.

## Interface
- UNIT_TICKS, 1: number of TICK pulses per dot unit; legal range 1..255.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- TICK  in  1  time-base enable from the divider; each CLK rising edge with TICK=1 counts one tick.
- START  in  1  request to send a character; sampled on rising CLK.
- SPACE  in  1  request for a word-space extension; sampled on rising CLK.
- PATTERN  in  5  element codes; bit i is element i (1=dash, 0=dot); bit 0 is sent first.
- LENGTH  in  3  number of elements, 0..5; values 6 and 7 are clamped to 5.
- KEY  out  1  registered; 1 while a mark (tone) is active.
- BUSY  out  1  registered; 1 from request acceptance until completion.
- DONE  out  1  registered; one-CLK pulse marking completion.

## Operation
- States: IDLE, MARK, EGAP (inter-element gap), CGAP (character gap), WGAP (word gap).
- Registers: tick counter tcnt (8 bit, counts 0..UNIT_TICKS-1), unit counter ucnt (3 bit), element index eidx (3 bit), and latched PATTERN and clamped LENGTH.
- A unit completes on the tick where tcnt = UNIT_TICKS-1; tcnt then wraps to 0.
- IDLE behaviour:
  - START=1 latches PATTERN and LENGTH and sets eidx=0.
  - If LENGTH≥1, go to MARK with KEY=1. If LENGTH=0, go to CGAP.
  - START=0 and SPACE=1: go to WGAP.
  - START and SPACE both high: START wins and SPACE is dropped.
- MARK lasts 1 unit for a dot and 3 units for a dash, then:
  - if elements remain, go to EGAP with KEY=0;
  - otherwise go to CGAP with KEY=0.
- EGAP lasts 1 unit, then increments eidx and goes to MARK with KEY=1.
- CGAP lasts 3 units. WGAP lasts 4 units, so a character gap followed by a word gap totals the standard 7 units.
- When CGAP or WGAP ends: go to IDLE, set BUSY=0 and DONE=1 for one cycle.
- START and SPACE are ignored while BUSY=1. There is no queueing.
- tcnt and ucnt clear on every state entry.

## Timing
- Reset values: KEY=0, BUSY=0, DONE=0, state IDLE, all counters 0. Reset applies immediately and asynchronously.
- Reset mid-operation aborts the character: KEY falls at once and no DONE is produced.
- Acceptance latency: a request sampled at edge k makes BUSY=1 (and KEY=1 for a mark) visible right after edge k.
- A TICK coincident with the accepting edge is not counted. Counting starts at edge k+1.
- Every phase boundary falls on the edge that samples the phase's final tick. Outputs change at that same edge, with no extra cycle.
- Total character duration is (sum of mark units + (LENGTH-1) + 3) × UNIT_TICKS ticks. For LENGTH=0 it is 3 × UNIT_TICKS ticks.
- DONE is high for exactly one CLK, concurrent with the first cycle of BUSY=0.
- A START sampled while DONE=1 is accepted, so characters can be sent back to back with no dead cycle.
- TICK held high on consecutive CLKs counts once per CLK.

## Test plan
- UNIT_TICKS=1, TICK=1 every cycle, START with PATTERN=5'b00010 and LENGTH=2 ("A"):
  - required: KEY=1 for 1 cycle, 0 for 1, 1 for 3, 0 for 3;
  - DONE pulses 8 cycles after acceptance.
- TICK driven by a divide-by-10 pulse, PATTERN=0, LENGTH=1 ("E"):
  - required: KEY high for exactly 10 CLKs;
  - BUSY high for 40 CLKs (±9 for tick phase), then one DONE pulse.
- SPACE alone, UNIT_TICKS=2, TICK every cycle:
  - required: KEY stays 0, BUSY=1 for 8 cycles, then one DONE.
  - Also drive START and SPACE high together: the character is sent and SPACE is ignored.
- PATTERN=5'b11111 with LENGTH=7 (clamped to 5, "0"), plus extra START pulses while BUSY=1:
  - required: 22 units total, 5 dashes;
  - the extra STARTs have no effect.
- Back-to-back: START asserted in the DONE cycle with "E":
  - required: new KEY=1 on the very next edge.
- RST pulsed mid-dash:
  - required: KEY, BUSY and DONE go 0 asynchronously, with no DONE pulse;
  - the next START behaves normally.
